ex_operand_stage: RTL and testbench

ID/EX pipeline register plus operand-forwarding logic, directly upstream of the ALU in the pipelined RV32I core. Captures decoded instruction fields and control each cycle and honours stall/flush from the hazard unit. Forwards MEM/WB results onto the source operands, then drives the ALU's `a`, `b` and `alucontrol` inputs. Also reports load-use hazards back to the hazard unit.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fwd_mux.sv | 35 +++
 rtl/ex_operand_stage.sv | 145 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes, result-source encodings
// and forwarding-select values.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass: picks the MEM result, then the WB result, then the
// register-file value. x0 is never bypassed.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_val,
    input  logic [REGW-1:0] m_rd,
    input  logic            m_regwrite,
    input  logic [XLEN-1:0] m_val,
    input  logic [REGW-1:0] w_rd,
    input  logic            w_regwrite,
    input  logic [XLEN-1:0] w_val,
    output logic [XLEN-1:0] fwd_val,
    output fwd_sel_e        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        fwd_val = rf_val;
        if (rs != '0) begin
            if (m_regwrite && (m_rd == rs)) begin
                fwd_sel = FWD_MEM;
                fwd_val = m_val;
            end else if (w_regwrite && (w_rd == rs)) begin
                fwd_sel = FWD_WB;
                fwd_val = w_val;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU,
// plus load-use hazard detection against the decode slot.
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            d_valid,
    input  logic [REGW-1:0] d_rs1,
    input  logic [REGW-1:0] d_rs2,
    input  logic [REGW-1:0] d_rd,
    input  logic [XLEN-1:0] d_rd1,
    input  logic [XLEN-1:0] d_rd2,
    input  logic [XLEN-1:0] d_imm,
    input  logic [XLEN-1:0] d_pc,
    input  logic [3:0]      d_alucontrol,
    input  logic            d_alusrc_a,
    input  logic            d_alusrc_b,
    input  logic            d_regwrite,
    input  logic            d_memwrite,
    input  logic            d_branch,
    input  logic            d_jump,
    input  logic [1:0]      d_resultsrc,
    input  logic [2:0]      d_funct3,
    input  logic [REGW-1:0] m_rd,
    input  logic            m_regwrite,
    input  logic [XLEN-1:0] m_aluresult,
    input  logic [REGW-1:0] w_rd,
    input  logic            w_regwrite,
    input  logic [XLEN-1:0] w_result,
    output logic            e_valid,
    output logic [XLEN-1:0] e_a,
    output logic [XLEN-1:0] e_b,
    output logic [3:0]      e_alucontrol,
    output logic [XLEN-1:0] e_writedata,
    output logic [REGW-1:0] e_rd,
    output logic [XLEN-1:0] e_pc,
    output logic [2:0]      e_funct3,
    output logic            e_regwrite,
    output logic            e_memwrite,
    output logic            e_branch,
    output logic            e_jump,
    output logic [1:0]      e_resultsrc,
    output logic            load_use
);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [3:0]      alucontrol;
        logic            alusrc_a;
        logic            alusrc_b;
        logic            regwrite;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic [1:0]      resultsrc;
        logic [2:0]      funct3;
    } ex_reg_t;

    ex_reg_t         ex_q, ex_d;
    logic [XLEN-1:0] rs1_val, rs2_val;
    fwd_sel_e        rs1_sel, rs2_sel;

    // An all-zero record is a valid bubble: ADD, RES_ALU, no side effects.
    always_comb begin
        ex_d = ex_q;
        if (flush_e || (!stall_e && !d_valid)) begin
            ex_d = '0;
            ex_d.alucontrol = ALU_ADD;
            ex_d.resultsrc  = RES_ALU;
        end else if (!stall_e) begin
            ex_d.valid      = 1'b1;
            ex_d.rs1        = d_rs1;
            ex_d.rs2        = d_rs2;
            ex_d.rd         = d_rd;
            ex_d.rd1        = d_rd1;
            ex_d.rd2        = d_rd2;
            ex_d.imm        = d_imm;
            ex_d.pc         = d_pc;
            ex_d.alucontrol = d_alucontrol;
            ex_d.alusrc_a   = d_alusrc_a;
            ex_d.alusrc_b   = d_alusrc_b;
            ex_d.regwrite   = d_regwrite;
            ex_d.memwrite   = d_memwrite;
            ex_d.branch     = d_branch;
            ex_d.jump       = d_jump;
            ex_d.resultsrc  = d_resultsrc;
            ex_d.funct3     = d_funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs(ex_q.rs1), .rf_val(ex_q.rd1),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_val(m_aluresult),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_val(w_result),
        .fwd_val(rs1_val), .fwd_sel(rs1_sel)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs(ex_q.rs2), .rf_val(ex_q.rd2),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_val(m_aluresult),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_val(w_result),
        .fwd_val(rs2_val), .fwd_sel(rs2_sel)
    );

    x0_rs1_not_forwarded: assert property (@(posedge clk) disable iff (reset)
        (ex_q.rs1 != '0) || (rs1_sel == FWD_RF));
    x0_rs2_not_forwarded: assert property (@(posedge clk) disable iff (reset)
        (ex_q.rs2 != '0) || (rs2_sel == FWD_RF));

    assign e_valid      = ex_q.valid;
    assign e_a          = ex_q.alusrc_a ? ex_q.pc  : rs1_val;
    assign e_b          = ex_q.alusrc_b ? ex_q.imm : rs2_val;
    assign e_writedata  = rs2_val;
    assign e_alucontrol = ex_q.alucontrol;
    assign e_rd         = ex_q.rd;
    assign e_pc         = ex_q.pc;
    assign e_funct3     = ex_q.funct3;
    assign e_regwrite   = ex_q.regwrite;
    assign e_memwrite   = ex_q.memwrite;
    assign e_branch     = ex_q.branch;
    assign e_jump       = ex_q.jump;
    assign e_resultsrc  = ex_q.resultsrc;

    assign load_use = ex_q.valid && (ex_q.resultsrc == RES_LOAD) && (ex_q.rd != '0)
                   && d_valid && ((d_rs1 == ex_q.rd) || (d_rs2 == ex_q.rd));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: capture, forwarding priority,
// operand select, load-use, stall/flush and asynchronous reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_e, flush_e, d_valid;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_rd1, d_rd2, d_imm, d_pc;
    logic [3:0]  d_alucontrol;
    logic        d_alusrc_a, d_alusrc_b, d_regwrite, d_memwrite, d_branch, d_jump;
    logic [1:0]  d_resultsrc;
    logic [2:0]  d_funct3;
    logic [4:0]  m_rd, w_rd;
    logic        m_regwrite, w_regwrite;
    logic [31:0] m_aluresult, w_result;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_writedata, e_pc;
    logic [3:0]  e_alucontrol;
    logic [4:0]  e_rd;
    logic [2:0]  e_funct3;
    logic        e_regwrite, e_memwrite, e_branch, e_jump;
    logic [1:0]  e_resultsrc;
    logic        load_use;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc),
        .d_alucontrol(d_alucontrol), .d_alusrc_a(d_alusrc_a), .d_alusrc_b(d_alusrc_b),
        .d_regwrite(d_regwrite), .d_memwrite(d_memwrite), .d_branch(d_branch),
        .d_jump(d_jump), .d_resultsrc(d_resultsrc), .d_funct3(d_funct3),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_aluresult(m_aluresult),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_result(w_result),
        .e_valid(e_valid), .e_a(e_a), .e_b(e_b), .e_alucontrol(e_alucontrol),
        .e_writedata(e_writedata), .e_rd(e_rd), .e_pc(e_pc), .e_funct3(e_funct3),
        .e_regwrite(e_regwrite), .e_memwrite(e_memwrite), .e_branch(e_branch),
        .e_jump(e_jump), .e_resultsrc(e_resultsrc), .load_use(load_use)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_e = 0; flush_e = 0; d_valid = 0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_pc = 0;
        d_alucontrol = 0; d_alusrc_a = 0; d_alusrc_b = 0; d_regwrite = 0;
        d_memwrite = 0; d_branch = 0; d_jump = 0; d_resultsrc = 0; d_funct3 = 0;
        m_rd = 0; m_regwrite = 0; m_aluresult = 0;
        w_rd = 0; w_regwrite = 0; w_result = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] alu);
        d_valid = 1; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
        d_rd1 = rd1; d_rd2 = rd2; d_imm = imm; d_pc = pc; d_alucontrol = alu;
        d_alusrc_a = 0; d_alusrc_b = 0; d_regwrite = 1; d_memwrite = 0;
        d_branch = 0; d_jump = 0; d_resultsrc = 2'b00; d_funct3 = 3'b000;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #12;
        check("rst_valid",    {31'd0, e_valid},      32'd0);
        check("rst_alu",      {28'd0, e_alucontrol}, 32'd0);
        check("rst_regwrite", {31'd0, e_regwrite},   32'd0);
        check("rst_pc",       e_pc,                  32'd0);
        check("rst_load_use", {31'd0, load_use},     32'd0);
        reset = 0;

        // add x3,x1,x2
        set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100, 32'h40, 4'b0000);
        tick();
        check("add_valid", {31'd0, e_valid}, 32'd1);
        check("add_a",     e_a,              32'd5);
        check("add_b",     e_b,              32'd7);
        check("add_rd",    {27'd0, e_rd},    32'd3);
        check("add_wdata", e_writedata,      32'd7);
        check("add_pc",    e_pc,             32'h40);

        // forwarding priority on rs1 = x1
        m_rd = 1; m_regwrite = 1; m_aluresult = 32'hAA;
        w_rd = 1; w_regwrite = 1; w_result = 32'hBB;
        #1 check("fwd_mem_wins", e_a, 32'hAA);
        m_regwrite = 0;
        #1 check("fwd_wb", e_a, 32'hBB);
        w_rd = 2;
        #1 check("fwd_wb_rs2_b",     e_b,         32'hBB);
        check("fwd_wb_rs2_wdata",    e_writedata, 32'hBB);
        check("fwd_rf_rs1",          e_a,         32'd5);

        // x0 never forwarded
        set_instr(5'd0, 5'd2, 5'd4, 32'h55, 32'h66, 32'h0, 32'h44, 4'b0000);
        w_regwrite = 0;
        tick();
        m_rd = 0; m_regwrite = 1; w_rd = 0; w_regwrite = 1;
        #1 check("x0_no_fwd", e_a, 32'h55);
        m_regwrite = 0; w_regwrite = 0;

        // alusrc: pc / imm, store data still the forwarded rs2
        set_instr(5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 32'h100, 32'h40, 4'b0000);
        d_alusrc_a = 1; d_alusrc_b = 1;
        tick();
        w_rd = 2; w_regwrite = 1; w_result = 32'hBB;
        #1 check("src_a_pc",     e_a,         32'h40);
        check("src_b_imm",       e_b,         32'h100);
        check("src_wdata_fwd",   e_writedata, 32'hBB);
        w_regwrite = 0;

        // lw x5 in EX, decode reads x5
        set_instr(5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'h8, 32'h50, 4'b0000);
        d_resultsrc = 2'b01; d_funct3 = 3'b010;
        tick();
        check("lw_resultsrc", {30'd0, e_resultsrc}, 32'd1);
        check("lw_funct3",    {29'd0, e_funct3},    32'd2);
        d_rs1 = 6; d_rs2 = 5; d_valid = 1;
        #1 check("load_use_hit", {31'd0, load_use}, 32'd1);
        d_rs2 = 6;
        #1 check("load_use_miss", {31'd0, load_use}, 32'd0);
        d_rs1 = 5; d_valid = 0;
        #1 check("load_use_dvalid0", {31'd0, load_use}, 32'd0);

        // stall holds everything while decode changes
        set_instr(5'd8, 5'd9, 5'd7, 32'h11, 32'h22, 32'h0, 32'h80, 4'b0001);
        d_memwrite = 1; d_branch = 1;
        tick();
        stall_e = 1;
        set_instr(5'd10, 5'd11, 5'd9, 32'h99, 32'h98, 32'h4, 32'h90, 4'b0011);
        tick();
        check("stall1_rd", {27'd0, e_rd}, 32'd7);
        check("stall1_a",  e_a,           32'h11);
        tick();
        check("stall2_rd",    {27'd0, e_rd},         32'd7);
        check("stall2_pc",    e_pc,                  32'h80);
        check("stall2_b",     e_b,                   32'h22);
        check("stall2_alu",   {28'd0, e_alucontrol}, 32'd1);
        check("stall2_mw",    {31'd0, e_memwrite},   32'd1);
        m_rd = 8; m_regwrite = 1; m_aluresult = 32'hC0DE;
        #1 check("stall_fwd_pickup", e_a, 32'hC0DE);
        m_regwrite = 0;

        // flush beats stall
        flush_e = 1;
        tick();
        check("flush_valid",  {31'd0, e_valid},      32'd0);
        check("flush_rw",     {31'd0, e_regwrite},   32'd0);
        check("flush_mw",     {31'd0, e_memwrite},   32'd0);
        check("flush_branch", {31'd0, e_branch},     32'd0);
        check("flush_alu",    {28'd0, e_alucontrol}, 32'd0);
        flush_e = 0; stall_e = 0;

        // d_valid=0 captured as bubble
        d_valid = 0;
        tick();
        check("bubble_valid", {31'd0, e_valid},    32'd0);
        check("bubble_rw",    {31'd0, e_regwrite}, 32'd0);

        // asynchronous reset between edges
        set_instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 32'h60, 4'b0010);
        tick();
        check("pre_reset_valid", {31'd0, e_valid}, 32'd1);
        stall_e = 1;
        #2 reset = 1;
        #1 check("async_rst_valid", {31'd0, e_valid},      32'd0);
        check("async_rst_alu",      {28'd0, e_alucontrol}, 32'd0);
        check("async_rst_pc",       e_pc,                  32'd0);
        #3 reset = 0;
        stall_e = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
